// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 bits on device clock falls, ACK check.
// Latency: INHIBIT_CYCLES + device clocking; ignores tx_start while busy, no queueing.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       KBCLK,
    input  logic       KBDAT,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       kbclk_low,
    output logic       kbdat_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SEND,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    state_t           state;
    logic [9:0]       shift;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;

    logic clk_s1, clk_sync, clk_prev;
    logic dat_s1, dat_sync;
    logic fall;

    assign fall = clk_prev & ~clk_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_s1   <= KBCLK;
            clk_sync <= clk_s1;
            clk_prev <= clk_sync;
            dat_s1   <= KBDAT;
            dat_sync <= dat_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            kbclk_low <= 1'b0;
            kbdat_low <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        shift     <= {1'b1, ~^tx_data, tx_data};
                        cnt       <= '0;
                        kbclk_low <= 1'b1;
                        busy      <= 1'b1;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        kbclk_low <= 1'b0;
                        kbdat_low <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    // The RELEASE cycle itself is the first cycle of the ACK timeout window.
                    cnt     <= CNT_W'(1);
                    bit_cnt <= '0;
                    state   <= SEND;
                end
                SEND, WAIT_ACK, WAIT_IDLE: begin
                    if (cnt == TO_LAST) begin
                        tx_err    <= 1'b1;
                        kbclk_low <= 1'b0;
                        kbdat_low <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (state == SEND) begin
                            if (fall) begin
                                // Shift register ends with the stop bit (1), which releases the line.
                                kbdat_low <= ~shift[0];
                                shift     <= {1'b0, shift[9:1]};
                                bit_cnt   <= bit_cnt + 4'd1;
                                if (bit_cnt == 4'd9) begin
                                    state <= WAIT_ACK;
                                end
                            end
                        end else if (state == WAIT_ACK) begin
                            if (fall) begin
                                if (!dat_sync) begin
                                    state <= WAIT_IDLE;
                                end else begin
                                    tx_err <= 1'b1;
                                    busy   <= 1'b0;
                                    state  <= IDLE;
                                end
                            end
                        end else begin
                            if (clk_sync && dat_sync) begin
                                tx_done <= 1'b1;
                                busy    <= 1'b0;
                                state   <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    kbclk_low <= 1'b0;
                    kbdat_low <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: table vectors, random bytes against a frame model, reset and timeout corners.
module tb_ps2_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       kbclk_low, kbdat_low, busy, tx_done, tx_err;
    logic       dev_clk, dev_dat;
    wire        KBCLK = dev_clk & ~kbclk_low;
    wire        KBDAT = dev_dat & ~kbdat_low;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    ps2_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(400)) dut (
        .clk(clk), .rst(rst), .KBCLK(KBCLK), .KBDAT(KBDAT),
        .tx_start(tx_start), .tx_data(tx_data),
        .kbclk_low(kbclk_low), .kbdat_low(kbdat_low), .busy(busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) both_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        bit         dev_clocks;
        bit         dev_ack;
        bit         intrude;
        bit         exp_parity;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Line contents seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones;
        logic [10:0] f;
        ones = 0;
        for (int k = 0; k < 8; k++) ones += int'(d[k]);
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[k+1] = d[k];
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic run_frame(input logic [7:0] d, input bit dev_clocks, input bit dev_ack,
                             input bit intrude, input int rst_fall,
                             output logic [10:0] seen, output int inh_len, output bit start_ok,
                             output int err_lat, output int n_done, output int n_err);
        int d0, e0, guard;
        d0 = done_cnt;
        e0 = err_cnt;
        seen = '1;
        err_lat = -1;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        inh_len = 0;
        while (kbclk_low && inh_len < 100) begin
            inh_len++;
            @(negedge clk);
        end
        start_ok = kbdat_low;
        if (!dev_clocks) begin
            err_lat = 0;
            while (!tx_err && err_lat < 1000) begin
                @(negedge clk);
                err_lat++;
            end
        end else begin
            repeat (5) @(negedge clk);
            seen[0] = KBDAT;
            for (int i = 1; i <= 11; i++) begin
                dev_clk = 1'b0;
                if (i == 11 && dev_ack) dev_dat = 1'b0;
                if (i == rst_fall) begin
                    repeat (3) @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_kbclk_low", kbclk_low, 0);
                    chk("rst_kbdat_low", kbdat_low, 0);
                    chk("rst_busy", busy, 0);
                    dev_clk = 1'b1;
                    break;
                end
                for (int j = 0; j < 10; j++) begin
                    if (intrude && i == 4 && j == 2) begin
                        tx_start = 1'b1;
                        tx_data  = 8'h55;
                    end else begin
                        tx_start = 1'b0;
                    end
                    @(negedge clk);
                end
                if (i <= 10) seen[i] = KBDAT;
                dev_clk = 1'b1;
                repeat (10) @(negedge clk);
                if (i == 11) dev_dat = 1'b1;
            end
        end
        guard = 0;
        while (busy && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        n_done = done_cnt - d0;
        n_err  = err_cnt - e0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [10:0] seen;
        int inh_len, err_lat, n_done, n_err;
        bit start_ok;
        run_frame(v.data, v.dev_clocks, v.dev_ack, v.intrude, 0,
                  seen, inh_len, start_ok, err_lat, n_done, n_err);
        chk({tag, "_inhibit_len"}, inh_len, 10);
        chk({tag, "_start_drive"}, start_ok, 1);
        if (v.dev_clocks) begin
            chk({tag, "_frame_bits"}, seen, model_frame(v.data));
            chk({tag, "_parity_bit"}, seen[9], v.exp_parity);
        end else begin
            chk({tag, "_timeout_latency"}, err_lat, 400);
        end
        chk({tag, "_done_pulses"}, n_done, v.exp_done);
        chk({tag, "_err_pulses"}, n_err, v.exp_err);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_lines_end"}, {kbclk_low, kbdat_low}, 0);
        chk({tag, "_both_pulses"}, both_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] seen;
        int inh_len, err_lat, n_done, n_err;
        bit start_ok;
        vec_t rv;

        vecs[0] = '{8'hED, 1, 1, 0, 1'b1, 1, 0};
        vecs[1] = '{8'h07, 1, 1, 0, 1'b0, 1, 0};
        vecs[2] = '{8'h00, 1, 1, 0, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1, 1, 0, 1'b1, 1, 0};
        vecs[4] = '{8'hED, 0, 0, 0, 1'b1, 0, 1};
        vecs[5] = '{8'hED, 1, 0, 0, 1'b1, 0, 1};
        vecs[6] = '{8'hED, 1, 1, 1, 1'b1, 1, 0};

        rst = 1'b1;
        tx_start = 1'b0;
        tx_data = 8'h00;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {kbclk_low, kbdat_low, busy, tx_done, tx_err}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

        for (int n = 0; n < 6; n++) begin
            rv.data       = 8'($urandom);
            rv.dev_clocks = 1;
            rv.dev_ack    = ($urandom_range(0, 3) != 0);
            rv.intrude    = 0;
            rv.exp_parity = model_frame(rv.data)[9];
            rv.exp_done   = rv.dev_ack ? 1 : 0;
            rv.exp_err    = rv.dev_ack ? 0 : 1;
            run_vec(rv, $sformatf("rand%0d", n));
        end

        run_frame(8'hED, 1, 1, 0, 5, seen, inh_len, start_ok, err_lat, n_done, n_err);
        chk("midrst_done", n_done, 0);
        chk("midrst_err", n_err, 0);
        dev_dat = 1'b1;
        repeat (5) @(negedge clk);
        run_vec(vecs[3], "after_rst");

        @(negedge clk);
        rst = 1'b1;
        tx_start = 1'b1;
        tx_data = 8'hED;
        @(negedge clk);
        rst = 1'b0;
        tx_start = 1'b0;
        chk("rst_start_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("rst_start_lines", {kbclk_low, kbdat_low, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
